fetch_aligner: RTL

Instruction fetch front-end that sits directly upstream of the cpu core's instruction input. It issues word-aligned reads to instruction memory and buffers the returned halfwords. From that buffer it presents one aligned instruction per handshake: 16-bit compressed (RVC) or 32-bit, including 32-bit instructions that straddle a word boundary. It also handles PC redirects from branches and jumps, and discards any stale in-flight fetch.

---
 rtl/fetch_aligner.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: word-aligned fetches into a 4-halfword queue, presenting
// one aligned 16-bit (RVC) or 32-bit instruction per handshake, with PC redirect.
module fetch_aligner #(
  parameter logic [31:0] RESET = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  output logic [31:0] O_mem_addr,
  output logic        O_mem_req,
  input  logic [31:0] I_mem_rdata,
  input  logic        I_mem_rvalid,
  output logic [31:0] O_inst,
  output logic [31:0] O_inst_pc,
  output logic        O_inst_valid,
  output logic        O_is_compressed,
  input  logic        I_inst_ready,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc
);

  logic [63:0] hq_q, hq_d, hq_shift;
  logic [2:0]  cnt_q, cnt_nxt, base, n_pop, n_push;
  logic [31:0] pc_q, fetch_q;
  logic        pending_q, discard_q, skip_low_q;

  logic [15:0] hq0, hq1;
  logic        is_rvc, inst_valid, pop, rv_eff, push, mem_req;
  logic [15:0] first_hw;

  assign hq0    = hq_q[15:0];
  assign hq1    = hq_q[31:16];
  assign is_rvc = (hq0[1:0] != 2'b11);

  assign inst_valid = is_rvc ? (cnt_q >= 3'd1) : (cnt_q >= 3'd2);
  assign pop        = inst_valid & I_inst_ready & ~I_redirect;
  assign n_pop      = !pop ? 3'd0 : (is_rvc ? 3'd1 : 3'd2);

  // A response is only meaningful if we actually have a request outstanding.
  assign rv_eff   = I_mem_rvalid & pending_q;
  assign push     = rv_eff & ~discard_q & ~I_redirect;
  assign n_push   = !push ? 3'd0 : (skip_low_q ? 3'd1 : 3'd2);
  assign first_hw = skip_low_q ? I_mem_rdata[31:16] : I_mem_rdata[15:0];

  assign base    = cnt_q - n_pop;
  assign cnt_nxt = base + n_push;

  // Requesting only when at most 2 halfwords are queued guarantees room for the reply.
  assign mem_req = I_rst & ~I_redirect & (~pending_q | rv_eff)
                 & ~(discard_q & pending_q) & (cnt_nxt <= 3'd2);

  always_comb begin
    hq_shift = hq_q;
    case (n_pop)
      3'd1:    hq_shift = {16'h0000, hq_q[63:16]};
      3'd2:    hq_shift = {32'h0000_0000, hq_q[63:32]};
      default: hq_shift = hq_q;
    endcase
    hq_d = hq_shift;
    for (int i = 0; i < 4; i++) begin
      if (push && (base == 3'(i)))
        hq_d[16*i +: 16] = first_hw;
      if (push && !skip_low_q && ((base + 3'd1) == 3'(i)))
        hq_d[16*i +: 16] = I_mem_rdata[31:16];
    end
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      hq_q       <= '0;
      cnt_q      <= '0;
      pc_q       <= RESET & ~32'h1;
      fetch_q    <= RESET & ~32'h3;
      skip_low_q <= RESET[1];
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else if (I_redirect) begin
      cnt_q      <= '0;
      pc_q       <= I_redirect_pc & ~32'h1;
      fetch_q    <= I_redirect_pc & ~32'h3;
      skip_low_q <= I_redirect_pc[1];
      // A request still in flight must have its reply dropped when it lands.
      pending_q  <= pending_q & ~I_mem_rvalid;
      discard_q  <= pending_q & ~I_mem_rvalid;
    end else begin
      hq_q  <= hq_d;
      cnt_q <= cnt_nxt;
      if (pop)
        pc_q <= pc_q + (is_rvc ? 32'd2 : 32'd4);
      if (mem_req) begin
        fetch_q   <= fetch_q + 32'd4;
        pending_q <= 1'b1;
      end else if (rv_eff) begin
        pending_q <= 1'b0;
      end
      if (rv_eff && discard_q)
        discard_q <= 1'b0;
      if (push)
        skip_low_q <= 1'b0;
    end
  end

  assign O_mem_req       = mem_req;
  assign O_mem_addr      = mem_req ? fetch_q : 32'h0;
  assign O_inst_valid    = inst_valid;
  assign O_is_compressed = inst_valid & is_rvc;
  assign O_inst          = !inst_valid ? 32'h0 : (is_rvc ? {16'h0000, hq0} : {hq1, hq0});
  assign O_inst_pc       = inst_valid ? pc_q : 32'h0;

endmodule
